execute_stage: RTL
==================

Name: execute_stage

Overview:
- Y86-64 pipeline execute stage, sitting between the D/E pipeline register and the memory stage.
- Forms the ALU operands and function select and sends them to the existing 64-bit ALU (sel 00 add, 01 sub, 10 and, 11 xor; outputs result and overflow).
- Consumes the ALU result and overflow to maintain the condition-code register (ZF/SF/OF) and evaluate branch/cmov conditions.
- Loads the E/M pipeline register, with stall and bubble control.

Parameters:
- DATA_W, 64, datapath width.
- REG_W, 4, register-ID width (0xF = RNONE).
- STAT_W, 3, status-code width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- E_stat  in  STAT_W  status of the instruction in E.
- E_icode  in  4  icode.
- E_ifun  in  4  ifun.
- E_valA  in  DATA_W  register operand A.
- E_valB  in  DATA_W  register operand B.
- E_valC  in  DATA_W  constant word.
- E_dstE  in  REG_W  E-destination register.
- E_dstM  in  REG_W  M-destination register.
- set_cc_en  in  1  from pipeline control; 0 when m_stat/W_stat is an exception.
- M_stall  in  1  hold the E/M register.
- M_bubble  in  1  inject a NOP into the E/M register.
- alu_a  out  DATA_W  to ALU port a.
- alu_b  out  DATA_W  to ALU port b.
- alu_sel  out  2  to ALU sel.
- alu_result  in  DATA_W  from ALU.
- alu_overflow  in  1  from ALU.
- e_cnd  out  1  combinational condition result, used for forwarding/misprediction.
- e_dstE  out  REG_W  combinational dstE after cmov squash, used for forwarding.
- e_valE  out  DATA_W  equals alu_result, used for forwarding.
- cc_zf  out  1  registered zero flag.
- cc_sf  out  1  registered sign flag.
- cc_of  out  1  registered overflow flag.
- M_stat  out  STAT_W  registered status.
- M_icode  out  4  registered icode.
- M_cnd  out  1  registered condition.
- M_valE  out  DATA_W  registered ALU result.
- M_valA  out  DATA_W  registered operand A.
- M_dstE  out  REG_W  registered E-destination.
- M_dstM  out  REG_W  registered M-destination.

Behaviour:
- Reset: one clock, clk; asynchronous active-high reset, rst.
- rst asserted, at any time including mid-operation, immediately forces:
  - CC to ZF=1, SF=0, OF=0.
  - E/M register to bubble: M_stat=SBUB, M_icode=INOP, M_cnd=0, M_valE=0, M_valA=0, M_dstE=RNONE, M_dstM=RNONE.
- Operand select (combinational). Internal aluA/aluB:
  - aluA = E_valA for RRMOVQ or OPQ.
  - aluA = E_valC for IRMOVQ, RMMOVQ or MRMOVQ.
  - aluA = -8 for CALL or PUSHQ.
  - aluA = +8 for RET or POPQ.
  - aluA = 0 otherwise.
  - aluB = E_valB for RMMOVQ, MRMOVQ, OPQ, CALL, PUSHQ, RET or POPQ.
  - aluB = 0 otherwise.
- ALU drive:
  - alu_a = aluB and alu_b = aluA, so subq yields valB - valA.
  - alu_sel = E_ifun[1:0] when icode is OPQ, else 2'b00.
- CC update, on the rising edge:
  - Condition: E_icode==OPQ && set_cc_en && !rst.
  - ZF = (alu_result==0), SF = alu_result[DATA_W-1], OF = alu_overflow.
  - Otherwise hold. CC updates even when M_stall or M_bubble is asserted.
- Condition evaluation (combinational, uses the current registered CC), keyed on E_ifun:
  - 0 always: 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: !ZF.
  - 5 ge: !(SF^OF).
  - 6 g: !(SF^OF)&!ZF.
  - 7–15: 0.
  - e_cnd is meaningful only for JXX/RRMOVQ; it is still driven for other icodes.
- e_dstE = RNONE if E_icode==RRMOVQ && !e_cnd, else E_dstE.
- E/M register priority: rst > M_bubble > M_stall > load.
  - Bubble loads the reset values.
  - Stall holds all M_* outputs.
  - Load captures E_stat, E_icode, e_cnd, alu_result, E_valA, e_dstE, E_dstM.
- Latency: one cycle from E_* to M_*. CC visible to the following instruction one cycle after the OPQ.
- Overflow: taken from the ALU as-is; 0 for andq/xorq. Arithmetic wraps modulo 2^64.

Decomposition:
- Package y86_pkg holds:
  - icode constants: IHALT 0, INOP 1, IRRMOVQ 2, IIRMOVQ 3, IRMMOVQ 4, IMRMOVQ 5, IOPQ 6, IJXX 7, ICALL 8, IRET 9, IPUSHQ A, IPOPQ B.
  - RNONE 4'hF.
  - Stat codes: SBUB 0, SAOK 1, SHLT 2, SADR 3, SINS 4.
  - Condition ifun codes.
- Sub-module cc_cond: CC register plus condition evaluator, with ports clk, rst, set, zf_in, sf_in, of_in, ifun -> zf, sf, of, cnd.

Test Plan:
- Reset, then release. Required: cc = {ZF1,SF0,OF0}, M_icode=1, M_dstE=F, M_stat=0. Then OPQ subq with valA=5, valB=5 (ALU returns 0). Required: next edge ZF=1, SF=0, M_valE=0, alu_sel=01, alu_a=5.
- addq, valA=valB=0x7FFF_FFFF_FFFF_FFFF, ALU overflow=1, result 0xFFFF_FFFF_FFFF_FFFE. Required: OF=1, SF=1, ZF=0. Then jl (ifun 2) -> e_cnd=0 (SF^OF=0). Then jle -> e_cnd=0.
- cmovne (RRMOVQ, ifun 4) with ZF=1, E_dstE=3. Required: e_dstE=F, M_dstE=F, M_cnd=0. Same with ZF=0 -> M_dstE=3.
- PUSHQ with valB=0x100. Required: alu_a=0x100, alu_b=-8, alu_sel=00, M_valE=0xF8, CC unchanged.
- OPQ with set_cc_en=0. Required: CC unchanged.
- M_stall=1 for 2 cycles. Required: M_* unchanged. Then M_bubble and M_stall both 1 -> bubble loaded.
- Assert rst mid-stream between edges with CC={0,1,1}. Required: CC -> {1,0,0} and M_* -> bubble values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register IDs, status codes
// and the jump/cmov condition function codes.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [2:0] SBUB    = 3'd0;
  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SHLT    = 3'd2;
  localparam logic [2:0] SADR    = 3'd3;
  localparam logic [2:0] SINS    = 3'd4;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

endpackage

// File: rtl/execute_stage_cc_cond.sv
// Condition-code register (ZF/SF/OF) and the jump/cmov condition evaluator
// that reads the registered flags.
module cc_cond
  import y86_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic       zf_in,
  input  logic       sf_in,
  input  logic       of_in,
  input  logic [3:0] ifun,
  output logic       zf,
  output logic       sf,
  output logic       of,
  output logic       cnd
);

  logic r_zf;
  logic r_sf;
  logic r_of;
  logic w_lt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (set) begin
      r_zf <= zf_in;
      r_sf <= sf_in;
      r_of <= of_in;
    end
  end

  assign zf   = r_zf;
  assign sf   = r_sf;
  assign of   = r_of;
  assign w_lt = r_sf ^ r_of;

  // Undefined function codes never take the branch / move.
  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = w_lt | r_zf;
      C_L:      cnd = w_lt;
      C_E:      cnd = r_zf;
      C_NE:     cnd = ~r_zf;
      C_GE:     cnd = ~w_lt;
      C_G:      cnd = ~w_lt & ~r_zf;
      default:  cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand/function selection, condition codes,
// cmov squash and the E/M pipeline register with stall/bubble control.
module execute_stage
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_W  = 4,
  parameter int STAT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAT_W-1:0] E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [DATA_W-1:0] E_valA,
  input  logic [DATA_W-1:0] E_valB,
  input  logic [DATA_W-1:0] E_valC,
  input  logic [REG_W-1:0]  E_dstE,
  input  logic [REG_W-1:0]  E_dstM,
  input  logic              set_cc_en,
  input  logic              M_stall,
  input  logic              M_bubble,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  output logic              e_cnd,
  output logic [REG_W-1:0]  e_dstE,
  output logic [DATA_W-1:0] e_valE,
  output logic              cc_zf,
  output logic              cc_sf,
  output logic              cc_of,
  output logic [STAT_W-1:0] M_stat,
  output logic [3:0]        M_icode,
  output logic              M_cnd,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [REG_W-1:0]  M_dstE,
  output logic [REG_W-1:0]  M_dstM
);

  localparam logic [REG_W-1:0] W_RNONE = {REG_W{1'b1}};

  logic [DATA_W-1:0] w_aluA;
  logic [DATA_W-1:0] w_aluB;
  logic              w_is_opq;
  logic              w_cnd;

  logic [STAT_W-1:0] r_stat_p1;
  logic [3:0]        r_icode_p1;
  logic              r_cnd_p1;
  logic [DATA_W-1:0] r_valE_p1;
  logic [DATA_W-1:0] r_valA_p1;
  logic [REG_W-1:0]  r_dstE_p1;
  logic [REG_W-1:0]  r_dstM_p1;

  assign w_is_opq = (E_icode == IOPQ);

  always_comb begin
    w_aluA = '0;
    case (E_icode)
      IRRMOVQ, IOPQ:            w_aluA = E_valA;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: w_aluA = E_valC;
      ICALL, IPUSHQ:            w_aluA = ~DATA_W'(7);
      IRET, IPOPQ:              w_aluA = DATA_W'(8);
      default:                  w_aluA = '0;
    endcase
  end

  always_comb begin
    w_aluB = '0;
    case (E_icode)
      IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IPUSHQ, IRET, IPOPQ: w_aluB = E_valB;
      default:                                            w_aluB = '0;
    endcase
  end

  // Operands cross over so that subq computes valB - valA.
  assign alu_a   = w_aluB;
  assign alu_b   = w_aluA;
  assign alu_sel = w_is_opq ? E_ifun[1:0] : 2'b00;

  cc_cond u_cc_cond (
    .clk   (clk),
    .rst   (rst),
    .set   (w_is_opq & set_cc_en),
    .zf_in (alu_result == '0),
    .sf_in (alu_result[DATA_W-1]),
    .of_in (alu_overflow),
    .ifun  (E_ifun),
    .zf    (cc_zf),
    .sf    (cc_sf),
    .of    (cc_of),
    .cnd   (w_cnd)
  );

  assign e_cnd  = w_cnd;
  assign e_dstE = ((E_icode == IRRMOVQ) && !w_cnd) ? W_RNONE : E_dstE;
  assign e_valE = alu_result;

  // ---- stage boundary: E -> M ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_p1  <= STAT_W'(SBUB);
      r_icode_p1 <= INOP;
      r_cnd_p1   <= 1'b0;
      r_valE_p1  <= '0;
      r_valA_p1  <= '0;
      r_dstE_p1  <= W_RNONE;
      r_dstM_p1  <= W_RNONE;
    end else if (M_bubble) begin
      r_stat_p1  <= STAT_W'(SBUB);
      r_icode_p1 <= INOP;
      r_cnd_p1   <= 1'b0;
      r_valE_p1  <= '0;
      r_valA_p1  <= '0;
      r_dstE_p1  <= W_RNONE;
      r_dstM_p1  <= W_RNONE;
    end else if (!M_stall) begin
      r_stat_p1  <= E_stat;
      r_icode_p1 <= E_icode;
      r_cnd_p1   <= w_cnd;
      r_valE_p1  <= alu_result;
      r_valA_p1  <= E_valA;
      r_dstE_p1  <= e_dstE;
      r_dstM_p1  <= E_dstM;
    end
  end

  assign M_stat  = r_stat_p1;
  assign M_icode = r_icode_p1;
  assign M_cnd   = r_cnd_p1;
  assign M_valE  = r_valE_p1;
  assign M_valA  = r_valA_p1;
  assign M_dstE  = r_dstE_p1;
  assign M_dstM  = r_dstM_p1;

endmodule
